// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high pulses on a 1-bit line in clock ticks.
// Latches the width of each accepted pulse, keeps a wrapping count of accepted
// pulses and strobes valid for one cycle per accepted pulse.
// Optional macro LOW_WIDTH_EN adds low-gap timing (low_width/low_valid).
module pulse_width_meter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MIN_WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0,
    output logic [WIDTH-1:0] width,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             overflow,
`ifdef LOW_WIDTH_EN
    output logic [WIDTH-1:0] low_width,
    output logic             low_valid,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] RunMax = '1;
    localparam logic [WIDTH-1:0] RunOne = WIDTH'(1);
    localparam logic [WIDTH-1:0] MinRun = WIDTH'(MIN_WIDTH);

    typedef enum logic [1:0] {
        StArm,
        StIdle,
        StHigh
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] run_q, run_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] width_q, width_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    // Next-state logic: pulse timing, saturation and evaluation on the first low sample.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        sat_d      = sat_q;
        width_d    = width_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            // A pulse in progress at reset release is discarded here.
            StArm: begin
                if (!in0) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (in0) begin
                    state_d = StHigh;
                    run_d   = RunOne;
                    sat_d   = (RunOne == RunMax);
                end
            end
            StHigh: begin
                if (in0) begin
                    if (run_q != RunMax) begin
                        run_d = run_q + RunOne;
                    end
                    if (run_q >= RunMax - RunOne) begin
                        sat_d = 1'b1;
                    end
                end else begin
                    if (run_q >= MinRun) begin
                        width_d    = run_q;
                        overflow_d = sat_q;
                        count_d    = count_q + RunOne;
                        valid_d    = 1'b1;
                    end
                    state_d = StIdle;
                    run_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = StArm;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArm;
            run_q      <= '0;
            sat_q      <= 1'b0;
            width_q    <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            sat_q      <= sat_d;
            width_q    <= width_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign width    = width_q;
    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    // Derived from the state register only, so no path from in0.
    assign busy     = (state_q == StHigh);

`ifdef LOW_WIDTH_EN
    logic [WIDTH-1:0] gap_q, gap_d;
    logic             gap_armed_q, gap_armed_d;
    logic [WIDTH-1:0] low_width_q, low_width_d;
    logic             low_valid_q, low_valid_d;

    // Gap timing: starts at 1 on the sample that ends a pulse, reported on the next rise.
    always_comb begin
        gap_d       = gap_q;
        gap_armed_d = gap_armed_q;
        low_width_d = low_width_q;
        low_valid_d = 1'b0;
        case (state_q)
            StArm: begin
                gap_armed_d = 1'b0;
            end
            StIdle: begin
                if (in0) begin
                    if (gap_armed_q) begin
                        low_width_d = gap_q;
                        low_valid_d = 1'b1;
                    end
                end else if (gap_q != RunMax) begin
                    gap_d = gap_q + RunOne;
                end
            end
            StHigh: begin
                if (!in0) begin
                    gap_d       = RunOne;
                    gap_armed_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gap counter and low-gap result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q       <= '0;
            gap_armed_q <= 1'b0;
            low_width_q <= '0;
            low_valid_q <= 1'b0;
        end else begin
            gap_q       <= gap_d;
            gap_armed_q <= gap_armed_d;
            low_width_q <= low_width_d;
            low_valid_q <= low_valid_d;
        end
    end

    assign low_width = low_width_q;
    assign low_valid = low_valid_q;
`endif

endmodule
